// File: rtl/image_proc_engine_if.sv
// Bus between the pixel engine and its source/destination image stores plus
// the start/busy/done handshake. The engine uses the slave modport.
interface image_proc_engine_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned CH_W   = 8
);
    localparam int unsigned PW = 3 * CH_W;

    logic              start;
    logic [1:0]        mode;
    logic [PW-1:0]     in_pix;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic              out_we;
    logic [PW-1:0]     out_pix;
    logic              busy;
    logic              done;

    modport master (
        output start, mode, in_pix,
        input  row, col, out_we, out_pix, busy, done
    );

    modport slave (
        input  start, mode, in_pix,
        output row, col, out_we, out_pix, busy, done
    );
endinterface

// File: rtl/image_proc_engine.sv
// Whole-image pixel transform engine: mirrors, 180-degree rotation or min/max
// grayscale, one pixel per RD/WR cycle pair, raster-order destination writes.
module image_proc_engine #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned CH_W   = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    image_proc_engine_if.slave  bus
);
    localparam int unsigned PW = 3 * CH_W;
    localparam logic [ADDR_W-1:0] Last = '1;

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] r_q, r_d;
    logic [ADDR_W-1:0] c_q, c_d;
    logic [1:0]        mode_q, mode_d;
    logic [PW-1:0]     pix_q, pix_d;

    logic [CH_W-1:0]   ch_r, ch_g, ch_b, mn, mx;
    logic [CH_W:0]     sum;
    logic [PW-1:0]     xf_pix;
    logic              flip_r, flip_c;

    // pix_q holds the already-transformed pixel so out_pix is a plain register.
    always_comb begin
        ch_r = bus.in_pix[PW-1:2*CH_W];
        ch_g = bus.in_pix[2*CH_W-1:CH_W];
        ch_b = bus.in_pix[CH_W-1:0];
        mn   = ch_r;
        if (ch_g < mn) mn = ch_g;
        if (ch_b < mn) mn = ch_b;
        mx   = ch_r;
        if (ch_g > mx) mx = ch_g;
        if (ch_b > mx) mx = ch_b;
        sum  = {1'b0, mn} + {1'b0, mx};
        if (mode_q == 2'd3) begin
            xf_pix = {{CH_W{1'b0}}, sum[CH_W:1], {CH_W{1'b0}}};
        end else begin
            xf_pix = bus.in_pix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            r_q     <= '0;
            c_q     <= '0;
            mode_q  <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            mode_q  <= mode_d;
            pix_q   <= pix_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        mode_d  = mode_q;
        pix_d   = pix_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    mode_d  = bus.mode;
                    r_d     = '0;
                    c_d     = '0;
                    state_d = StRd;
                end
            end
            StRd: begin
                pix_d   = xf_pix;
                state_d = StWr;
            end
            StWr: begin
                if (r_q == Last && c_q == Last) begin
                    state_d = StDone;
                end else begin
                    c_d = c_q + 1'b1;
                    if (c_q == Last) r_d = r_q + 1'b1;
                    state_d = StRd;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // N-1-x equals ~x because the image side is a power of two.
    always_comb begin
        flip_r  = (mode_q == 2'd0) || (mode_q == 2'd2);
        flip_c  = (mode_q == 2'd1) || (mode_q == 2'd2);
        bus.row = '0;
        bus.col = '0;
        unique case (state_q)
            StRd: begin
                bus.row = flip_r ? ~r_q : r_q;
                bus.col = flip_c ? ~c_q : c_q;
            end
            StWr: begin
                bus.row = r_q;
                bus.col = c_q;
            end
            default: begin
                bus.row = '0;
                bus.col = '0;
            end
        endcase
    end

    assign bus.out_we  = (state_q == StWr);
    assign bus.busy    = (state_q == StRd) || (state_q == StWr);
    assign bus.done    = (state_q == StDone);
    assign bus.out_pix = pix_q;
endmodule

// File: tb/tb_image_proc_engine.sv
// Directed bench for image_proc_engine: scoreboard of expected destination
// writes for a 4x4 and an 8x8 instance, plus handshake and abort scenarios.
module tb_image_proc_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    image_proc_engine_if #(.ADDR_W(2), .CH_W(8)) if2 ();
    image_proc_engine_if #(.ADDR_W(3), .CH_W(8)) if3 ();

    image_proc_engine #(.ADDR_W(2), .CH_W(8)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2.slave)
    );
    image_proc_engine #(.ADDR_W(3), .CH_W(8)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if3.slave)
    );

    logic [23:0] src2 [16];
    logic [23:0] dst2 [16];
    logic [23:0] src3 [64];
    logic [23:0] dst3 [64];

    assign if2.in_pix = src2[{if2.row, if2.col}];
    assign if3.in_pix = src3[{if3.row, if3.col}];

    always @(posedge clk) begin
        if (if2.out_we) dst2[{if2.row, if2.col}] <= if2.out_pix;
        if (if3.out_we) dst3[{if3.row, if3.col}] <= if3.out_pix;
    end

    typedef struct {
        int          row;
        int          col;
        logic [23:0] pix;
    } wr_t;

    wr_t q2[$];
    wr_t q3[$];
    int  checks = 0;
    int  failures = 0;
    int  wr_cnt [4];
    int  busy_cnt [4];
    int  done_cnt [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] gray(input logic [23:0] p);
        logic [7:0] a, b, c, lo, hi;
        logic [8:0] s;
        a  = p[23:16];
        b  = p[15:8];
        c  = p[7:0];
        lo = (a < b) ? a : b;
        lo = (lo < c) ? lo : c;
        hi = (a > b) ? a : b;
        hi = (hi > c) ? hi : c;
        s  = {1'b0, lo} + {1'b0, hi};
        return {8'h00, s[8:1], 8'h00};
    endfunction

    always @(negedge clk) begin : mon
        wr_t e;
        if (rst_n) begin
            if (if2.busy) busy_cnt[2]++;
            if (if2.done) done_cnt[2]++;
            if (if3.busy) busy_cnt[3]++;
            if (if3.done) done_cnt[3]++;
            if (if2.out_we) begin
                wr_cnt[2]++;
                checks++;
                assert (q2.size() != 0) else begin
                    failures++;
                    $error("FAIL wr2_extra observed=write@%0d,%0d expected=none",
                           if2.row, if2.col);
                end
                if (q2.size() != 0) begin
                    e = q2.pop_front();
                    chk("wr2", {if2.row, if2.col, if2.out_pix},
                        {e.row[1:0], e.col[1:0], e.pix});
                end
            end
            if (if3.out_we) begin
                wr_cnt[3]++;
                checks++;
                assert (q3.size() != 0) else begin
                    failures++;
                    $error("FAIL wr3_extra observed=write@%0d,%0d expected=none",
                           if3.row, if3.col);
                end
                if (q3.size() != 0) begin
                    e = q3.pop_front();
                    chk("wr3", {if3.row, if3.col, if3.out_pix},
                        {e.row[2:0], e.col[2:0], e.pix});
                end
            end
        end
    end

    function automatic logic done_of(input int sel);
        return (sel == 2) ? if2.done : if3.done;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 2) ? if2.busy : if3.busy;
    endfunction

    task automatic set_start(input int sel, input logic s, input logic [1:0] m);
        if (sel == 2) begin
            if2.start = s;
            if2.mode  = m;
        end else begin
            if3.start = s;
            if3.mode  = m;
        end
    endtask

    task automatic clr(input int sel);
        wr_cnt[sel]   = 0;
        busy_cnt[sel] = 0;
        done_cnt[sel] = 0;
    endtask

    // Expected raster-order writes straight from the source-coordinate table.
    task automatic push_exp(input int sel, input logic [1:0] m, input int lim);
        int  n;
        wr_t e;
        n = (sel == 2) ? 4 : 8;
        for (int k = 0; k < lim; k++) begin
            int r, c, sr, sc;
            r  = k / n;
            c  = k % n;
            sr = (m == 2'd0 || m == 2'd2) ? n - 1 - r : r;
            sc = (m == 2'd1 || m == 2'd2) ? n - 1 - c : c;
            e.row = r;
            e.col = c;
            e.pix = (sel == 2) ? src2[sr*n+sc] : src3[sr*n+sc];
            if (m == 2'd3) e.pix = gray(e.pix);
            if (sel == 2) q2.push_back(e);
            else q3.push_back(e);
        end
    endtask

    task automatic start_run(input int sel, input logic [1:0] m);
        clr(sel);
        set_start(sel, 1'b1, m);
        @(posedge clk);
        #1 set_start(sel, 1'b0, m);
    endtask

    task automatic wait_done(input int sel, output int n);
        n = 0;
        forever begin
            @(posedge clk);
            n++;
            #1;
            if (done_of(sel) || n >= 5000) break;
        end
    endtask

    // Called in the done cycle; checks pulse width and per-run totals.
    task automatic finish_run(input int sel, input int nn);
        @(posedge clk);
        #1;
        chk("done_width", done_of(sel), 1'b0);
        chk("busy_after_done", busy_of(sel), 1'b0);
        chk("write_count", wr_cnt[sel], nn);
        chk("busy_cycles", busy_cnt[sel], 2 * nn);
        chk("done_count", done_cnt[sel], 1);
        chk("queue_empty", (sel == 2) ? q2.size() : q3.size(), 0);
    endtask

    task automatic run(input int sel, input logic [1:0] m);
        int n, nn;
        nn = (sel == 2) ? 16 : 64;
        push_exp(sel, m, nn);
        start_run(sel, m);
        wait_done(sel, n);
        // done appears after 2*N*N edges past the accept edge.
        chk("latency", n, 2 * nn);
        finish_run(sel, nn);
    endtask

    task automatic fill_pattern();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) src2[r*4+c] = {8'(r), 8'(c), 8'hA5};
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) src3[r*8+c] = {8'(r), 8'(c), 8'hA5};
    endtask

    initial begin
        int n;
        logic [23:0] gpix [4];
        gpix[0] = 24'h102030;
        gpix[1] = 24'hFFFF00;
        gpix[2] = 24'h01FE80;
        gpix[3] = 24'h000000;
        fill_pattern();
        clr(2);
        clr(3);
        set_start(2, 1'b1, 2'd0);
        set_start(3, 1'b1, 2'd0);
        rst_n = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs2", {if2.row, if2.col, if2.out_we, if2.out_pix, if2.busy, if2.done}, '0);
        chk("rst_outs3", {if3.row, if3.col, if3.out_we, if3.out_pix, if3.busy, if3.done}, '0);
        set_start(2, 1'b0, 2'd0);
        set_start(3, 1'b0, 2'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_after_rst2", {if2.busy, if2.out_we, if2.done, if2.row, if2.col}, '0);
        chk("idle_after_rst3", {if3.busy, if3.out_we, if3.done, if3.row, if3.col}, '0);
        @(posedge clk);
        #1;

        // Vertical mirror 4x4, then horizontal mirror and rotate on 8x8.
        run(2, 2'd0);
        chk("vmirror_dst00", dst2[0], {8'd3, 8'd0, 8'hA5});
        chk("vmirror_dst33", dst2[15], {8'd0, 8'd3, 8'hA5});
        run(3, 2'd1);
        chk("hmirror_dst25", dst3[2*8+5], {8'd2, 8'd2, 8'hA5});
        run(3, 2'd2);
        chk("rot_dst00", dst3[0], {8'd7, 8'd7, 8'hA5});
        chk("rot_dst61", dst3[6*8+1], {8'd1, 8'd6, 8'hA5});

        for (int i = 0; i < 16; i++) src2[i] = gpix[i%4];
        run(2, 2'd3);
        chk("gray_0", dst2[0], 24'h002000);
        chk("gray_1", dst2[1], 24'h007F00);
        chk("gray_2", dst2[2], 24'h007F00);
        chk("gray_3", dst2[3], 24'h000000);

        // Stray starts mid-run and in the done cycle; mode toggled mid-run.
        fill_pattern();
        push_exp(2, 2'd0, 16);
        start_run(2, 2'd0);
        repeat (4) @(posedge clk);
        #1 set_start(2, 1'b1, 2'd1);
        @(posedge clk);
        #1 set_start(2, 1'b0, 2'd1);
        wait_done(2, n);
        chk("hs_latency", n + 5, 32);
        chk("hs_single_run_writes", wr_cnt[2], 16);
        chk("hs_queue_empty", q2.size(), 0);
        push_exp(2, 2'd2, 16);
        set_start(2, 1'b1, 2'd2);
        @(posedge clk);
        #1;
        chk("hs_done_count", done_cnt[2], 1);
        chk("hs_start_in_done_ignored", if2.busy, 1'b0);
        clr(2);
        @(posedge clk);
        #1 set_start(2, 1'b0, 2'd0);
        chk("hs_second_accept", if2.busy, 1'b1);
        wait_done(2, n);
        chk("hs2_latency", n, 32);
        finish_run(2, 16);

        // Reset during the WR cycle of write 7.
        push_exp(2, 2'd1, 7);
        start_run(2, 2'd1);
        repeat (15) @(posedge clk);
        #1;
        chk("abort_in_wr", if2.out_we, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_we_async", if2.out_we, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("abort_writes", wr_cnt[2], 7);
        chk("abort_queue", q2.size(), 0);
        chk("abort_no_done", done_cnt[2], 0);
        chk("abort_idle", if2.busy, 1'b0);
        @(posedge clk);
        #1;
        run(2, 2'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/image_proc_engine.md
# image_proc_engine

Parametrised pixel-processing engine for square images of 2^ADDR_W × 2^ADDR_W pixels with three CH_W-bit colour channels. One `start` pulse runs one selected transform over the whole image, one pixel per two cycles. The transform is vertical mirror, horizontal mirror, 180° rotation or min/max grayscale. The engine reads a source image store and writes a separate destination image store through a shared row/col address. It replaces the fixed 64×64 mirror/grayscale sequencer and adds a start/busy/done handshake, mode selection and reset.

## Interface
- ADDR_W, 6, row/col address width; image side N = 2^ADDR_W
- CH_W, 8, bits per colour channel; pixel width PW = 3*CH_W, R in [PW-1:2*CH_W], G in [2*CH_W-1:CH_W], B in [CH_W-1:0]

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- mode  in  2  0 = vertical mirror, 1 = horizontal mirror, 2 = rotate 180°, 3 = grayscale; latched when start is accepted
- in_pix  in  PW  source pixel at [row,col]; combinational read, valid in the same cycle
- row  out  ADDR_W  row address to both image stores
- col  out  ADDR_W  column address to both image stores
- out_we  out  1  destination write enable; the store writes out_pix at [row,col] on the rising edge
- out_pix  out  PW  destination pixel data
- busy  out  1  high from the cycle after accept until DONE is entered
- done  out  1  one-cycle pulse on completion

## Operation
- Registered FSM: IDLE → RD → WR → (RD | DONE) → IDLE.
- IDLE: row = col = 0, out_we = 0, busy = 0. `start` = 1 latches `mode`, clears the scan counters (r, c) and moves to RD.
- RD: row/col = source coordinate S(r,c). in_pix is captured into pix_q. out_we = 0.
- WR: row/col = (r,c). out_we = 1. out_pix = f(pix_q).
  - If (r,c) = (N-1,N-1), go to DONE.
  - Otherwise advance raster order: c increments; on c = N-1, c wraps to 0 and r increments. Go to RD.
- DONE: done = 1 and out_we = 0 for exactly one cycle, then IDLE.
- Source coordinates S(r,c):
  - mode 0: (N-1-r, c)
  - mode 1: (r, N-1-c)
  - mode 2: (N-1-r, N-1-c)
  - mode 3: (r, c)
- f(p) is the identity for modes 0–2.
- f(p) for mode 3:
  - mn = min(R,G,B), mx = max(R,G,B)
  - avg = (mn + mx) >> 1, computed at CH_W+1 bits with no overflow, truncated toward zero
  - out_pix = {0, avg, 0}: G carries avg, R = B = 0
- Source and destination are separate stores, so no in-place hazard exists and every destination pixel is written exactly once.
- `start` while busy or in DONE is ignored and does not queue. Changing `mode` mid-run has no effect.
- out_pix holds its last value outside WR. Only out_we qualifies it.

## Timing
- Reset (asynchronous, rst_n = 0): state = IDLE, r = c = 0, pix_q = 0, row = 0, col = 0, out_we = 0, out_pix = 0, busy = 0, done = 0. All outputs are registered or decoded from registered state.
- Reset asserted mid-run aborts immediately. Rows already written stay written; no done pulse is produced. After rst_n rises, the engine waits in IDLE.
- Accept at edge T0: the first RD cycle runs T0→T1 and the first write commits at edge T2.
- Write k (0-based) commits at edge T0 + 2k + 2.
- The last write commits at edge T0 + 2N²; done is high for the following cycle.
- Latency from start to done is 2N² + 1 cycles. The earliest next accept is the cycle after done.
- busy = 1 for exactly 2N² cycles per run.
- A start pulse in the done cycle is ignored. A start in the first IDLE cycle after done is accepted.

## Test plan
- Reset: hold rst_n = 0 with start = 1 → all outputs 0 and no writes. Release rst_n → still IDLE until the next start.
- Vertical mirror, ADDR_W = 2, source pixel = {r, c, 8'hA5} → destination [r][c] = {3-r, c, A5} for all 16 pixels. done at cycle 33 after accept. Exactly 16 out_we pulses.
- Horizontal mirror and rotate 180°, ADDR_W = 3, same pattern → destination [r][c] = {r, 7-c, A5} and {7-r, 7-c, A5} respectively. 64 writes each.
- Grayscale with pixels 0x102030, 0xFFFF00, 0x01FE80, 0x000000 → G = 0x20, 0x7F, 0x7F, 0x00 respectively, with R = B = 0.
- Handshake: start pulses at accept+5, at the done cycle, and with mode toggled mid-run → a single run in the original mode. A start in the cycle after done begins a second run.
- Mid-run abort: rst_n = 0 at write 7 → out_we drops asynchronously and done never pulses. A subsequent full run completes normally.
